lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
- Load/store initiator that drives the data memory's MemRead/MemWrite/addr/w_data port and consumes its combinational r_data.
- Accepts one LDUR/STUR-family request at a time from the MEM stage over a valid/ready handshake.
- Sub-word loads (byte, half, word): extracts the lane and zero- or sign-extends it.
- Sub-word stores: done as read-modify-write on the 64-bit doubleword memory.
- Signals alignment and range errors without touching memory.

Parameters:
- MEM_BYTES, 8192, addressable bytes of data memory (1024 doublewords); byte addresses >= MEM_BYTES raise resp_err.
- CHECK_ALIGN, 1, 1: a misaligned access (addr not a multiple of its size) raises resp_err. 0: low address bits are ignored (addr forced down to the size boundary).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_we  input  1  1=store, 0=load
- req_size  input  2  0=byte, 1=half, 2=word, 3=doubleword
- req_signed  input  1  sign-extend a sub-word load (LDURSW etc.)
- req_addr  input  `WORD  byte address
- req_wdata  input  `WORD  store data, right-justified
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  `WORD  extended load data (0 for stores and errors)
- resp_err  output  1  access rejected; qualified by resp_valid
- MemRead  output  1  memory read enable
- MemWrite  output  1  memory write enable
- addr  output  `WORD  doubleword-aligned byte address to memory
- w_data  output  `WORD  doubleword to write
- r_data  input  `WORD  memory read data, combinational from addr/MemRead

Behaviour:
- Clock and reset: single clock; rst_n is asynchronous, active-low. While rst_n=0:
  - state=IDLE
  - req_ready=0, resp_valid=0, resp_err=0
  - resp_rdata=0, MemRead=0, MemWrite=0, addr=0, w_data=0
  - all internal registers cleared
- Reset mid-operation aborts the access with no response. A pending RMW write is never issued.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1; memory outputs all 0.
  - On req_valid&&req_ready, latch we, size, signed, addr, wdata. Next state:
    - error → RESP with err flag set
    - load → READ
    - store with size=3 → WRITE
    - store with size<3 → READ
- READ:
  - MemRead=1, addr={addr_q[63:3],3'b000}.
  - Capture r_data at the clock edge.
  - Load → RESP, holding the extracted data.
  - Store → WRITE, holding the merged doubleword.
- WRITE:
  - MemWrite=1, same aligned addr, w_data=merged (or wdata_q when size=3).
  - Next state → RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, req_ready=0; next state IDLE.
  - No response backpressure: the consumer must take the pulse.
- Latency, from the accept edge T (resp_valid high during the cycle starting at):
  - load: T+2
  - doubleword store: T+2
  - sub-word store: T+3
  - error: T+1
- Throughput: back-to-back requests are accepted in the cycle after RESP.
- Lanes: little-endian. Byte offset o=addr_q[2:0]; byte i occupies bits [8i+7:8i].
- Load extract:
  - Field = size-wide slice starting at byte o.
  - req_signed=1: sign-extend from the field MSB; else zero-extend.
  - size=3 ignores req_signed.
- Store merge: replace only the bytes o..o+(1<<size)-1 of the captured doubleword with the low bytes of wdata_q; all other bytes are unchanged.
- Errors (checked at accept):
  - misaligned when CHECK_ALIGN=1
  - req_addr >= MEM_BYTES
  - On error: no MemRead/MemWrite cycle ever; resp_rdata=0.
- MemRead and MemWrite are never high in the same cycle.
- resp_rdata holds its value until the next RESP or reset.
- req_valid while req_ready=0 is ignored; the requester holds the request.

Test Plan:
- Reset asserted during WRITE of a store to 0x10 → MemWrite drops immediately, no response, doubleword at 0x10 unchanged, req_ready=1 one cycle after release.
- Memory word at 0x08 = 0x1122_3344_8899_AABB:
  - LDURB at 0x09 unsigned → resp_rdata=0x00000000000000AA at T+2.
  - Signed word load at 0x08 → 0xFFFFFFFF8899AABB.
- STURH 0xBEEF at 0x0A over 0x1122334455667788 → READ then WRITE with w_data=0x11223344BEEF7788, resp at T+3.
- STUR 0xDEADBEEFCAFEF00D at 0x20 → single WRITE cycle, no MemRead, resp at T+2; a following load of 0x20 returns the same value.
- Error cases, each with resp_err=1 at T+1 and memory enables never asserted:
  - Half load at 0x03 with CHECK_ALIGN=1.
  - Load at 0x2000 with MEM_BYTES=8192.
- Back-to-back: req_valid held with 4 loads → accepts every 3 cycles; req_ready low during READ/RESP; 4 resp_valid pulses in order.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response handshake and data-memory port of the load/store controller.
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [63:0] addr;
  logic [63:0] w_data;
  logic [63:0] r_data;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, r_data,
    output req_ready, resp_valid, resp_rdata, resp_err, MemRead, MemWrite, addr, w_data
  );
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, r_data,
    input  req_ready, resp_valid, resp_rdata, resp_err, MemRead, MemWrite, addr, w_data
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// LDUR/STUR-family initiator: sub-word loads with extension, sub-word stores as
// read-modify-write on the 64-bit doubleword memory, alignment/range rejection.
module lsu_byte_lane #(
  parameter int LANE = 0
) (
  input  logic [2:0] off,
  input  logic [1:0] size,
  input  logic [7:0] old_b,
  input  logic [7:0] new_b,
  output logic [7:0] out_b
);
  localparam logic [3:0] L = 4'(LANE);
  logic [3:0] lo, hi;
  always_comb begin
    lo    = {1'b0, off};
    hi    = lo + (4'd1 << size);
    out_b = (L >= lo && L < hi) ? new_b : old_b;
  end
endmodule

module lsu_mem_ctrl #(
  parameter int MEM_BYTES   = 8192,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  lsu_mem_ctrl_if.slave bus
);
  localparam int NUM_LANES = 8;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [63:0] addr;
    logic [63:0] wdata;
  } req_t;

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic        rdy_q, rdy_d;
  logic        err_q, err_d;
  logic [63:0] rdata_q, rdata_d;
  logic [63:0] merged_q, merged_d;

  logic [2:0]  amask;
  logic        acc_err;
  logic [63:0] rd_sh, ld_data, wsh;
  logic [NUM_LANES-1:0][7:0] old_b, new_b, mrg_b;

  // Byte-lane merge of the store data into the doubleword just read.
  assign wsh   = req_q.wdata << {req_q.addr[2:0], 3'b000};
  assign old_b = bus.r_data;
  assign new_b = wsh;
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    lsu_byte_lane #(.LANE(l)) u_lane (
      .off(req_q.addr[2:0]), .size(req_q.size),
      .old_b(old_b[l]), .new_b(new_b[l]), .out_b(mrg_b[l])
    );
  end

  always_comb begin
    rd_sh = bus.r_data >> {req_q.addr[2:0], 3'b000};
    case (req_q.size)
      2'd0:    ld_data = {{56{req_q.sgn & rd_sh[7]}},  rd_sh[7:0]};
      2'd1:    ld_data = {{48{req_q.sgn & rd_sh[15]}}, rd_sh[15:0]};
      2'd2:    ld_data = {{32{req_q.sgn & rd_sh[31]}}, rd_sh[31:0]};
      default: ld_data = rd_sh;
    endcase
  end

  always_comb begin
    case (bus.req_size)
      2'd0:    amask = 3'd0;
      2'd1:    amask = 3'd1;
      2'd2:    amask = 3'd3;
      default: amask = 3'd7;
    endcase
    acc_err = (bus.req_addr >= 64'(MEM_BYTES)) ||
              (CHECK_ALIGN && |(bus.req_addr[2:0] & amask));
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    merged_d = merged_q;
    case (state_q)
      IDLE: if (bus.req_valid && rdy_q) begin
        req_d.we    = bus.req_we;
        req_d.size  = bus.req_size;
        req_d.sgn   = bus.req_signed;
        req_d.wdata = bus.req_wdata;
        req_d.addr  = CHECK_ALIGN ? bus.req_addr
                                  : {bus.req_addr[63:3], bus.req_addr[2:0] & ~amask};
        err_d       = acc_err;
        if (acc_err) begin
          state_d = RESP;
          rdata_d = '0;
        end else if (bus.req_we && bus.req_size == 2'd3) begin
          state_d = WRITE;
        end else begin
          state_d = READ;
        end
      end
      READ: begin
        if (req_q.we) begin
          state_d  = WRITE;
          merged_d = mrg_b;
        end else begin
          state_d = RESP;
          rdata_d = ld_data;
        end
      end
      WRITE: begin
        state_d = RESP;
        rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= '0;
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      merged_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      rdy_q    <= rdy_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      merged_q <= merged_d;
    end
  end

  always_comb begin
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.addr     = '0;
    bus.w_data   = '0;
    if (state_q == READ) begin
      bus.MemRead = 1'b1;
      bus.addr    = {req_q.addr[63:3], 3'b000};
    end else if (state_q == WRITE) begin
      bus.MemWrite = 1'b1;
      bus.addr     = {req_q.addr[63:3], 3'b000};
      bus.w_data   = (req_q.size == 2'd3) ? req_q.wdata : merged_q;
    end
  end

  assign bus.req_ready  = rdy_q;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = (state_q == RESP) && err_q;
  assign bus.resp_rdata = rdata_q;
endmodule
